// File: rtl/alsu_cmd_sequencer_pkg.sv
`default_nettype none
// =============================================================================
// Module   : alsu_cmd_sequencer_pkg
// Brief    : Shared command type, park command and invalid-operation decode.
// Revision : 1.0 - initial release
// =============================================================================
package alsu_cmd_sequencer_pkg;

   typedef enum logic [2:0] {
      OR        = 3'd0,
      XOR       = 3'd1,
      ADD       = 3'd2,
      MULT      = 3'd3,
      SHIFT     = 3'd4,
      ROTATE    = 3'd5,
      INVALID_6 = 3'd6,
      INVALID_7 = 3'd7
   } opcode_e;

   typedef struct packed {
      opcode_e           opcode;
      logic signed [2:0] A;
      logic signed [2:0] B;
      logic              cin;
      logic              serial_in;
      logic              direction;
      logic              red_op_A;
      logic              red_op_B;
      logic              bypass_A;
      logic              bypass_B;
   } alsu_cmd_t;

   // OR of two zero operands keeps the ALSU output parked at zero.
   localparam alsu_cmd_t PARK_CMD = '{
      opcode:    OR,
      A:         3'sd0,
      B:         3'sd0,
      cin:       1'b0,
      serial_in: 1'b0,
      direction: 1'b0,
      red_op_A:  1'b0,
      red_op_B:  1'b0,
      bypass_A:  1'b0,
      bypass_B:  1'b0
   };

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      HOLD  = 2'd3
   } seq_state_e;

   function automatic logic is_invalid(input alsu_cmd_t c);
      logic bad_op;
      logic red_misuse;
      bad_op     = (c.opcode == INVALID_6) || (c.opcode == INVALID_7);
      red_misuse = (c.red_op_A || c.red_op_B) && (c.opcode != OR) && (c.opcode != XOR);
      return bad_op || red_misuse;
   endfunction

endpackage
`default_nettype wire

// File: rtl/alsu_cmd_sequencer_if.sv
`default_nettype none
// =============================================================================
// Module   : alsu_cmd_sequencer_if
// Brief    : Command, ALSU drive and result channels of the sequencer.
// Revision : 1.0 - initial release
// =============================================================================
interface alsu_cmd_sequencer_if #(
   parameter int TAG_W = 4
);
   import alsu_cmd_sequencer_pkg::*;

   logic              cmd_valid;
   logic              cmd_ready;
   opcode_e           cmd_opcode;
   logic signed [2:0] cmd_A;
   logic signed [2:0] cmd_B;
   logic              cmd_cin;
   logic              cmd_serial_in;
   logic              cmd_direction;
   logic              cmd_red_op_A;
   logic              cmd_red_op_B;
   logic              cmd_bypass_A;
   logic              cmd_bypass_B;

   logic signed [2:0] alsu_A;
   logic signed [2:0] alsu_B;
   opcode_e           alsu_opcode;
   logic              alsu_cin;
   logic              alsu_serial_in;
   logic              alsu_direction;
   logic              alsu_red_op_A;
   logic              alsu_red_op_B;
   logic              alsu_bypass_A;
   logic              alsu_bypass_B;
   logic              alsu_rst;
   logic signed [5:0] alsu_out;

   logic              res_valid;
   logic              res_ready;
   logic signed [5:0] res_out;
   logic              res_invalid;
   logic [TAG_W-1:0]  res_tag;
   logic              busy;

   // master: the sequencer; slave: command source, result sink and ALSU.
   modport master (
      input  cmd_valid, cmd_opcode, cmd_A, cmd_B, cmd_cin, cmd_serial_in,
             cmd_direction, cmd_red_op_A, cmd_red_op_B, cmd_bypass_A, cmd_bypass_B,
             alsu_out, res_ready,
      output cmd_ready, alsu_A, alsu_B, alsu_opcode, alsu_cin, alsu_serial_in,
             alsu_direction, alsu_red_op_A, alsu_red_op_B, alsu_bypass_A,
             alsu_bypass_B, alsu_rst, res_valid, res_out, res_invalid, res_tag, busy
   );

   modport slave (
      output cmd_valid, cmd_opcode, cmd_A, cmd_B, cmd_cin, cmd_serial_in,
             cmd_direction, cmd_red_op_A, cmd_red_op_B, cmd_bypass_A, cmd_bypass_B,
             alsu_out, res_ready,
      input  cmd_ready, alsu_A, alsu_B, alsu_opcode, alsu_cin, alsu_serial_in,
             alsu_direction, alsu_red_op_A, alsu_red_op_B, alsu_bypass_A,
             alsu_bypass_B, alsu_rst, res_valid, res_out, res_invalid, res_tag, busy
   );

endinterface
`default_nettype wire

// File: rtl/alsu_cmd_fifo.sv
`default_nettype none
// =============================================================================
// Module   : alsu_cmd_fifo
// Brief    : Synchronous command FIFO; pushes while full and pops while empty are dropped.
// Revision : 1.0 - initial release
// =============================================================================
module alsu_cmd_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_ptr_q;
   logic [AW:0]      rd_ptr_q;
   logic             w_push;
   logic             w_pop;

   // Extra pointer MSB distinguishes full from empty when the indices match.
   assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign w_push  = push_i && !full_o;
   assign w_pop   = pop_i && !empty_o;
   assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (w_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
         if (w_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
   end

endmodule
`default_nettype wire

// File: rtl/alsu_cmd_sequencer.sv
`default_nettype none
// =============================================================================
// Module   : alsu_cmd_sequencer
// Brief    : Queues ALSU commands, issues them one at a time and returns tagged results.
// Revision : 1.0 - initial release
// =============================================================================
module alsu_cmd_sequencer
   import alsu_cmd_sequencer_pkg::*;
#(
   parameter int DEPTH   = 8,
   parameter int LATENCY = 2,
   parameter int TAG_W   = 4
) (
   input logic                  clk,
   input logic                  rst,
   alsu_cmd_sequencer_if.master bus
);
   localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   seq_state_e        state_q, state_d;
   alsu_cmd_t         drive_q, drive_d;
   alsu_cmd_t         cmd_q, cmd_d;
   logic [CW-1:0]     wait_q, wait_d;
   logic signed [5:0] res_out_q, res_out_d;
   logic              res_invalid_q, res_invalid_d;
   logic [TAG_W-1:0]  res_tag_q, res_tag_d;
   logic [TAG_W-1:0]  tag_q, tag_d;

   alsu_cmd_t w_cmd_in;
   alsu_cmd_t w_head;
   logic      w_full;
   logic      w_empty;
   logic      w_pop;

   assign w_cmd_in = '{
      opcode:    bus.cmd_opcode,
      A:         bus.cmd_A,
      B:         bus.cmd_B,
      cin:       bus.cmd_cin,
      serial_in: bus.cmd_serial_in,
      direction: bus.cmd_direction,
      red_op_A:  bus.cmd_red_op_A,
      red_op_B:  bus.cmd_red_op_B,
      bypass_A:  bus.cmd_bypass_A,
      bypass_B:  bus.cmd_bypass_B
   };

   alsu_cmd_fifo #(
      .DEPTH (DEPTH),
      .WIDTH ($bits(alsu_cmd_t))
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (bus.cmd_valid),
      .wdata_i (w_cmd_in),
      .pop_i   (w_pop),
      .rdata_o (w_head),
      .full_o  (w_full),
      .empty_o (w_empty)
   );

   always_comb begin
      state_d       = state_q;
      drive_d       = drive_q;
      cmd_d         = cmd_q;
      wait_d        = wait_q;
      res_out_d     = res_out_q;
      res_invalid_d = res_invalid_q;
      res_tag_d     = res_tag_q;
      tag_d         = tag_q;
      w_pop         = 1'b0;
      case (state_q)
         IDLE: begin
            if (!w_empty) begin
               w_pop   = 1'b1;
               drive_d = w_head;
               cmd_d   = w_head;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            drive_d = PARK_CMD;
            wait_d  = CW'(LATENCY - 1);
            state_d = WAIT;
         end
         WAIT: begin
            if (wait_q == '0) begin
               res_out_d     = bus.alsu_out;
               res_invalid_d = is_invalid(cmd_q);
               res_tag_d     = tag_q;
               tag_d         = tag_q + TAG_W'(1);
               state_d       = HOLD;
            end else begin
               wait_d = wait_q - CW'(1);
            end
         end
         HOLD: begin
            // Back-to-back issue straight from HOLD keeps throughput at LATENCY+2.
            if (bus.res_ready) begin
               if (!w_empty) begin
                  w_pop   = 1'b1;
                  drive_d = w_head;
                  cmd_d   = w_head;
                  state_d = ISSUE;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         drive_q       <= PARK_CMD;
         cmd_q         <= PARK_CMD;
         wait_q        <= '0;
         res_out_q     <= '0;
         res_invalid_q <= 1'b0;
         res_tag_q     <= '0;
         tag_q         <= '0;
      end else begin
         state_q       <= state_d;
         drive_q       <= drive_d;
         cmd_q         <= cmd_d;
         wait_q        <= wait_d;
         res_out_q     <= res_out_d;
         res_invalid_q <= res_invalid_d;
         res_tag_q     <= res_tag_d;
         tag_q         <= tag_d;
      end
   end

   assign bus.cmd_ready      = !w_full;
   assign bus.alsu_opcode    = drive_q.opcode;
   assign bus.alsu_A         = drive_q.A;
   assign bus.alsu_B         = drive_q.B;
   assign bus.alsu_cin       = drive_q.cin;
   assign bus.alsu_serial_in = drive_q.serial_in;
   assign bus.alsu_direction = drive_q.direction;
   assign bus.alsu_red_op_A  = drive_q.red_op_A;
   assign bus.alsu_red_op_B  = drive_q.red_op_B;
   assign bus.alsu_bypass_A  = drive_q.bypass_A;
   assign bus.alsu_bypass_B  = drive_q.bypass_B;
   assign bus.alsu_rst       = rst;
   assign bus.res_valid      = (state_q == HOLD);
   assign bus.res_out        = res_out_q;
   assign bus.res_invalid    = res_invalid_q;
   assign bus.res_tag        = res_tag_q;
   assign bus.busy           = (state_q != IDLE) || !w_empty;

endmodule
`default_nettype wire

// File: tb/tb_alsu_cmd_sequencer.sv
`default_nettype none
// =============================================================================
// Module   : tb_alsu_cmd_sequencer
// Brief    : Directed self-checking bench with a two-stage behavioural ALSU.
// Revision : 1.0 - initial release
// =============================================================================
module tb_alsu_cmd_sequencer;
   import alsu_cmd_sequencer_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   alsu_cmd_sequencer_if #(.TAG_W(4)) bus ();

   alsu_cmd_sequencer #(
      .DEPTH   (8),
      .LATENCY (2),
      .TAG_W   (4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Behavioural ALSU: inputs registered on one edge, out registered on the next.
   opcode_e           m_op;
   logic signed [2:0] m_a, m_b;
   logic              m_cin, m_sin, m_dir, m_roa, m_rob, m_ba, m_bb;
   logic signed [5:0] m_out;

   function automatic logic signed [5:0] alsu_calc(
      input opcode_e op, input logic signed [2:0] a, input logic signed [2:0] b,
      input logic cin, input logic sin, input logic dir, input logic roa,
      input logic rob, input logic ba, input logic bb, input logic signed [5:0] cur);
      logic signed [5:0] ea, eb;
      ea = a;
      eb = b;
      if ((op == INVALID_6) || (op == INVALID_7) || ((roa || rob) && (op != OR) && (op != XOR)))
         return 6'sd0;
      if (ba) return ea;
      if (bb) return eb;
      case (op)
         OR:      return roa ? {5'd0, |a} : (rob ? {5'd0, |b} : (ea | eb));
         XOR:     return roa ? {5'd0, ^a} : (rob ? {5'd0, ^b} : (ea ^ eb));
         ADD:     return ea + eb + {5'd0, cin};
         MULT:    return ea * eb;
         SHIFT:   return dir ? {cur[4:0], sin} : {sin, cur[5:1]};
         ROTATE:  return dir ? {cur[4:0], cur[5]} : {cur[0], cur[5:1]};
         default: return 6'sd0;
      endcase
   endfunction

   always @(posedge clk) begin
      if (bus.alsu_rst) begin
         m_op <= OR; m_a <= '0; m_b <= '0; m_cin <= 1'b0; m_sin <= 1'b0; m_dir <= 1'b0;
         m_roa <= 1'b0; m_rob <= 1'b0; m_ba <= 1'b0; m_bb <= 1'b0; m_out <= '0;
      end else begin
         m_op <= bus.alsu_opcode; m_a <= bus.alsu_A; m_b <= bus.alsu_B;
         m_cin <= bus.alsu_cin; m_sin <= bus.alsu_serial_in; m_dir <= bus.alsu_direction;
         m_roa <= bus.alsu_red_op_A; m_rob <= bus.alsu_red_op_B;
         m_ba <= bus.alsu_bypass_A; m_bb <= bus.alsu_bypass_B;
         m_out <= alsu_calc(m_op, m_a, m_b, m_cin, m_sin, m_dir, m_roa, m_rob, m_ba, m_bb, m_out);
      end
   end
   assign bus.alsu_out = m_out;

   logic [15:0] drv;
   assign drv = {bus.alsu_opcode, bus.alsu_A, bus.alsu_B, bus.alsu_cin, bus.alsu_serial_in,
                 bus.alsu_direction, bus.alsu_red_op_A, bus.alsu_red_op_B,
                 bus.alsu_bypass_A, bus.alsu_bypass_B};

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // flags = {cin, serial_in, direction, red_op_A, red_op_B, bypass_A, bypass_B}
   task automatic set_cmd(input opcode_e op, input logic signed [2:0] a,
                          input logic signed [2:0] b, input logic [6:0] flags);
      bus.cmd_valid     = 1'b1;
      bus.cmd_opcode    = op;
      bus.cmd_A         = a;
      bus.cmd_B         = b;
      bus.cmd_cin       = flags[6];
      bus.cmd_serial_in = flags[5];
      bus.cmd_direction = flags[4];
      bus.cmd_red_op_A  = flags[3];
      bus.cmd_red_op_B  = flags[2];
      bus.cmd_bypass_A  = flags[1];
      bus.cmd_bypass_B  = flags[0];
   endtask

   task automatic wait_res(input string tag, input int bound);
      int n = 0;
      while ((bus.res_valid !== 1'b1) && (n < bound)) begin
         tick();
         n++;
      end
      chk(tag, {15'd0, bus.res_valid}, 16'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int bad;
      bus.res_ready = 1'b0;
      set_cmd(OR, 3'sd0, 3'sd0, 7'b0);
      bus.cmd_valid = 1'b0;

      // Reset state
      tick(); tick();
      chk("rst_cmd_ready", {15'd0, bus.cmd_ready}, 16'd1);
      chk("rst_res_valid", {15'd0, bus.res_valid}, 16'd0);
      chk("rst_res_out",   {10'd0, bus.res_out}, 16'd0);
      chk("rst_res_inv",   {15'd0, bus.res_invalid}, 16'd0);
      chk("rst_res_tag",   {12'd0, bus.res_tag}, 16'd0);
      chk("rst_busy",      {15'd0, bus.busy}, 16'd0);
      chk("rst_park",      drv, 16'd0);
      chk("rst_alsu_rst",  {15'd0, bus.alsu_rst}, 16'd1);
      rst = 1'b0;
      tick();
      chk("alsu_rst_low",  {15'd0, bus.alsu_rst}, 16'd0);

      // ADD 3 + -2, cycle-exact latency
      set_cmd(ADD, 3'sd3, -3'sd2, 7'b0);
      tick();
      bus.cmd_valid = 1'b0;
      chk("add_busy_t1",   {15'd0, bus.busy}, 16'd1);
      chk("add_park_t1",   drv, 16'd0);
      tick();
      chk("add_drive_t2",  drv, {3'd2, 3'b011, 3'b110, 7'b0});
      bus.res_ready = 1'b1;
      tick();
      chk("add_park_t3",   drv, 16'd0);
      tick();
      chk("add_novalid_t4", {15'd0, bus.res_valid}, 16'd0);
      tick();
      chk("add_valid_t5",  {15'd0, bus.res_valid}, 16'd1);
      chk("add_out",       {10'd0, bus.res_out}, 16'd1);
      chk("add_inv",       {15'd0, bus.res_invalid}, 16'd0);
      chk("add_tag",       {12'd0, bus.res_tag}, 16'd0);
      tick();
      chk("add_consumed",  {15'd0, bus.res_valid}, 16'd0);
      chk("add_idle",      {15'd0, bus.busy}, 16'd0);

      // MULT -3 * 2 twice back-to-back
      set_cmd(MULT, -3'sd3, 3'sd2, 7'b0);
      tick(); tick();
      bus.cmd_valid = 1'b0;
      chk("mul_drive1",    drv, {3'd3, 3'b101, 3'b010, 7'b0});
      tick();
      chk("mul_park1",     drv, 16'd0);
      tick(); tick();
      chk("mul_valid1",    {15'd0, bus.res_valid}, 16'd1);
      chk("mul_out1",      {10'd0, bus.res_out}, 16'h003A);
      chk("mul_tag1",      {12'd0, bus.res_tag}, 16'd1);
      tick();
      chk("mul_drive2",    drv, {3'd3, 3'b101, 3'b010, 7'b0});
      tick(); tick(); tick();
      chk("mul_valid2",    {15'd0, bus.res_valid}, 16'd1);
      chk("mul_out2",      {10'd0, bus.res_out}, 16'h003A);
      chk("mul_tag2",      {12'd0, bus.res_tag}, 16'd2);
      tick();
      chk("mul_idle",      {15'd0, bus.busy}, 16'd0);

      // Invalid operations: opcode 7, then ADD with red_op_A
      set_cmd(INVALID_7, 3'sd1, 3'sd1, 7'b0);
      tick();
      set_cmd(ADD, 3'sd1, 3'sd1, 7'b0001000);
      tick();
      bus.cmd_valid = 1'b0;
      wait_res("inv1_wait", 10);
      chk("inv1_flag",     {15'd0, bus.res_invalid}, 16'd1);
      chk("inv1_out",      {10'd0, bus.res_out}, 16'd0);
      chk("inv1_tag",      {12'd0, bus.res_tag}, 16'd3);
      tick();
      wait_res("inv2_wait", 10);
      chk("inv2_flag",     {15'd0, bus.res_invalid}, 16'd1);
      chk("inv2_out",      {10'd0, bus.res_out}, 16'd0);
      chk("inv2_tag",      {12'd0, bus.res_tag}, 16'd4);
      tick();

      // Back-pressure: 10 pushes with res_ready low, 9 accepted
      bus.res_ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         set_cmd(OR, 3'(i % 4), 3'sd0, 7'b0);
         chk($sformatf("fill_ready_%0d", i), {15'd0, bus.cmd_ready}, (i < 9) ? 16'd1 : 16'd0);
         tick();
      end
      bus.cmd_valid = 1'b0;
      for (int i = 0; i < 20; i++) begin
         chk("hold_stable", {4'd0, bus.res_valid, bus.res_invalid, bus.res_tag, bus.res_out},
             {4'd0, 1'b1, 1'b0, 4'd5, 6'd0});
         tick();
      end
      bus.res_ready = 1'b1;
      for (int k = 0; k < 9; k++) begin
         wait_res("drain_wait", 10);
         chk($sformatf("drain_out_%0d", k), {10'd0, bus.res_out}, 16'(k % 4));
         chk($sformatf("drain_tag_%0d", k), {12'd0, bus.res_tag}, 16'(5 + k));
         tick();
      end
      tick(); tick(); tick();
      chk("drain_done_valid", {15'd0, bus.res_valid}, 16'd0);
      chk("drain_done_busy",  {15'd0, bus.busy}, 16'd0);
      chk("drain_done_ready", {15'd0, bus.cmd_ready}, 16'd1);

      // SHIFT left from parked zero with serial_in=1
      set_cmd(SHIFT, 3'sd0, 3'sd0, 7'b0110000);
      tick();
      bus.cmd_valid = 1'b0;
      wait_res("shift_wait", 10);
      chk("shift_out",     {10'd0, bus.res_out}, 16'b000001);
      chk("shift_inv",     {15'd0, bus.res_invalid}, 16'd0);
      chk("shift_tag",     {12'd0, bus.res_tag}, 16'd14);
      tick();

      // Reset during WAIT with two more commands queued; push in reset cycle
      set_cmd(ADD, 3'sd1, 3'sd1, 7'b0);
      tick(); tick(); tick();
      chk("mid_busy",      {15'd0, bus.busy}, 16'd1);
      rst = 1'b1;
      tick();
      chk("mrst_valid",    {15'd0, bus.res_valid}, 16'd0);
      chk("mrst_busy",     {15'd0, bus.busy}, 16'd0);
      chk("mrst_ready",    {15'd0, bus.cmd_ready}, 16'd1);
      chk("mrst_park",     drv, 16'd0);
      chk("mrst_tag",      {12'd0, bus.res_tag}, 16'd0);
      rst = 1'b0;
      bus.cmd_valid = 1'b0;
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if ((bus.res_valid !== 1'b0) || (bus.busy !== 1'b0)) bad++;
      end
      chk("mrst_no_result", 16'(bad), 16'd0);
      set_cmd(ADD, 3'sd1, 3'sd2, 7'b0);
      tick();
      bus.cmd_valid = 1'b0;
      wait_res("post_rst_wait", 10);
      chk("post_rst_out",  {10'd0, bus.res_out}, 16'd3);
      chk("post_rst_tag",  {12'd0, bus.res_tag}, 16'd0);
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
